// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

    // Branch targets are word aligned: the low two bits are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {instr, pc} entries; flush empties it in one cycle.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    // A full buffer can still accept a push when its head leaves this cycle.
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign head_o    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; flush overrides any push or pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= entry_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, redirect on taken branch.
// Define FETCH_BUF2_EN for a 2-entry instruction buffer (default is 1 entry).
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  PCBranch,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

`ifdef FETCH_BUF2_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              slot_free_s;
    logic              buf_full_s;
    logic              buf_empty_s;
    fetch_entry_t      head_s;
    fetch_entry_t      entry_s;

    assign instr_valid = reset_n && !buf_empty_s && !PCSrc;
    assign pop_s       = instr_valid && instr_ready;
    // The response of a new request must find room once this cycle's pop is done.
    assign slot_free_s = !buf_full_s || pop_s;
    assign entry_s     = '{instr: imem_rdata, pc: req_pc_q};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (push_s),
        .entry_i (entry_s),
        .pop_i   (pop_s),
        .flush_i (PCSrc),
        .head_o  (head_s),
        .full_o  (buf_full_s),
        .empty_o (buf_empty_s)
    );

    // State, fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Next-state logic; a redirect always wins over issue and push.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        issue_s  = 1'b0;
        push_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PCSrc) begin
                    pc_d = align_pc(PCBranch);
                end else if (slot_free_s) begin
                    issue_s  = 1'b1;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_INCR;
                    state_d  = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (PCSrc) begin
                    pc_d    = align_pc(PCBranch);
                    state_d = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    push_s  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            DROP: begin
                if (PCSrc) begin
                    pc_d = align_pc(PCBranch);
                end else begin
                    pc_d = pc_q;
                end
                if (imem_rvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req  = reset_n && issue_s;
    assign imem_addr = reset_n ? pc_q : RESET_PC;
    assign instr     = reset_n ? head_s.instr : '0;
    assign instr_pc  = reset_n ? head_s.pc : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model plus directed scenarios.
module tb_fetch_stage;
    import fetch_pkg::*;

`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [63:0] RST_PC  = 64'h0;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        PCSrc;
    logic [63:0] PCBranch;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;

    logic        w_req;
    logic [63:0] w_addr;
    logic        w_rvalid;
    logic [31:0] w_rdata;
    logic        w_pcsrc;
    logic [63:0] w_branch;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_instr;
    logic [63:0] w_instr_pc;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PCSrc(PCSrc), .PCBranch(PCBranch),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    fetch_stage #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset_n(reset_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .PCSrc(w_pcsrc), .PCBranch(w_branch),
        .instr_valid(w_valid), .instr_ready(w_ready), .instr(w_instr), .instr_pc(w_instr_pc)
    );

    typedef struct {
        int          due;
        logic [63:0] addr;
    } resp_t;

    resp_t       resp_q[$];
    logic [63:0] m_buf[$];
    logic [63:0] req_log[$];
    logic [63:0] pop_log[$];
    bit          m_out;
    bit          m_want;
    logic [63:0] m_req_pc;
    logic [63:0] m_fetch_pc;
    bit          last_req;
    bit          w_nxt_v;
    logic [31:0] w_nxt_d;
    int          cyc;
    int          lat;
    int          w_n;
    int          w_p;
    int          n_tests;
    int          n_fail;
    int          mark_r;
    int          mark_p;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
    endfunction

    function automatic logic [63:0] qget(input logic [63:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock cycle: drive memory, check outputs at negedge, advance the model.
    task automatic tick();
        bit exp_valid;
        bit exp_pop;
        bit exp_req;
        int occ_after;
        if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(resp_q[0].addr);
            void'(resp_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        if (!reset_n) begin
            chk("rst_imem_req", imem_req, 64'd0);
            chk("rst_instr_valid", instr_valid, 64'd0);
            chk("rst_imem_addr", imem_addr, RST_PC);
            chk("rst_instr", instr, 64'd0);
            chk("rst_instr_pc", instr_pc, 64'd0);
            m_out = 1'b0;
            m_want = 1'b0;
            m_fetch_pc = RST_PC;
            m_buf.delete();
        end else begin
            exp_valid = (m_buf.size() > 0) && !PCSrc;
            exp_pop   = exp_valid && instr_ready;
            occ_after = m_buf.size() - (exp_pop ? 1 : 0);
            exp_req   = !m_out && !PCSrc && (occ_after < DEPTH);
            chk("instr_valid", instr_valid, exp_valid);
            chk("imem_req", imem_req, exp_req);
            if (exp_valid) begin
                chk("instr_pc", instr_pc, m_buf[0]);
                chk("instr", instr, word_of(m_buf[0]));
            end
            if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
            if (instr_valid && instr_ready) pop_log.push_back(instr_pc);
            if (exp_pop) void'(m_buf.pop_front());
            if (imem_rvalid && m_out) begin
                if (m_want && !PCSrc) m_buf.push_back(m_req_pc);
                m_out = 1'b0;
            end
            if (exp_req) begin
                m_out = 1'b1;
                m_want = 1'b1;
                m_req_pc = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 64'd4;
            end
            if (PCSrc) begin
                m_buf.delete();
                m_want = 1'b0;
                m_fetch_pc = {PCBranch[63:2], 2'b00};
            end
        end
        last_req = imem_req;
        if (imem_req) begin
            req_log.push_back(imem_addr);
            resp_q.push_back('{due: cyc + lat, addr: imem_addr});
        end
        if (reset_n && w_req) begin
            w_n++;
            if (w_n == 1) chk("wrap_addr0", w_addr, WRAP_PC);
            else if (w_n == 2) chk("wrap_addr1", w_addr, 64'h0);
        end
        if (reset_n && w_valid) begin
            w_p++;
            if (w_p == 1) begin
                chk("wrap_pc0", w_instr_pc, WRAP_PC);
                chk("wrap_instr0", w_instr, word_of(WRAP_PC));
            end else if (w_p == 2) begin
                chk("wrap_pc1", w_instr_pc, 64'h0);
            end
        end
        w_nxt_v = w_req;
        w_nxt_d = word_of(w_addr);
        @(posedge clk);
        #1;
        w_rvalid = w_nxt_v;
        w_rdata  = w_nxt_d;
        cyc++;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_req) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_req: no imem_req within 20 cycles (cycle %0d)", cyc);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; lat = 1; w_n = 0; w_p = 0;
        reset_n = 1'b0; PCSrc = 1'b0; PCBranch = 64'h0; instr_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        w_rvalid = 1'b0; w_rdata = 32'h0; w_pcsrc = 1'b0; w_branch = 64'h0; w_ready = 1'b1;
        repeat (3) tick();

        // Sequential fetch with a 1-cycle memory.
        reset_n = 1'b1;
        repeat (12) tick();
        chk("seq_addr0", qget(req_log, 0), 64'h0);
        chk("seq_addr1", qget(req_log, 1), 64'h4);
        chk("seq_addr2", qget(req_log, 2), 64'h8);
        chk("seq_pop0", qget(pop_log, 0), 64'h0);
        chk("seq_pop1", qget(pop_log, 1), 64'h4);
        chk("seq_pop2", qget(pop_log, 2), 64'h8);

        // Decode stall: buffer fills to its depth and fetching stops.
        instr_ready = 1'b0;
        repeat (6) tick();
        chk("stall_occupancy", m_buf.size(), DEPTH);
        instr_ready = 1'b1;
        repeat (6) tick();

        // Redirect while waiting; the late word must be dropped.
        lat = 2;
        wait_req();
        mark_r = req_log.size();
        mark_p = pop_log.size();
        PCSrc = 1'b1; PCBranch = 64'h103;
        tick();
        PCSrc = 1'b0; PCBranch = 64'h0;
        repeat (8) tick();
        chk("drop_next_addr", qget(req_log, mark_r), 64'h100);
        chk("drop_first_pop", qget(pop_log, mark_p), 64'h100);

        // Redirect in the same cycle as the response.
        wait_req();
        tick();
        mark_r = req_log.size();
        mark_p = pop_log.size();
        PCSrc = 1'b1; PCBranch = 64'h200;
        tick();
        PCSrc = 1'b0; PCBranch = 64'h0;
        tick();
        chk("same_cycle_addr", qget(req_log, mark_r), 64'h200);
        repeat (6) tick();
        chk("same_cycle_pop", qget(pop_log, mark_p), 64'h200);

        // Reset while waiting; the late response lands after release.
        lat = 3;
        wait_req();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        mark_r = req_log.size();
        mark_p = pop_log.size();
        repeat (10) tick();
        chk("post_rst_addr", qget(req_log, mark_r), RST_PC);
        chk("post_rst_pop", qget(pop_log, mark_p), RST_PC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, 64'h0, PC value loaded on reset.
REQ-002 clk  in  1  rising-edge clock, sole clock.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 imem_req  out  1  single-cycle fetch request pulse, accepted in the cycle asserted.
REQ-005 imem_addr  out  64  fetch address, valid when imem_req=1.
REQ-006 imem_rvalid  in  1  instruction word return strobe, latency >=1 cycle after imem_req.
REQ-007 imem_rdata  in  32  returned instruction word.
REQ-008 PCSrc  in  1  taken-branch redirect from the branch-resolve logic.
REQ-009 PCBranch  in  64  redirect target.
REQ-010 instr_valid  out  1  instr/instr_pc hold a valid fetched instruction.
REQ-011 instr_ready  in  1  decode consumes the head entry.
REQ-012 instr  out  32  instruction word; instr[31:21] is the decoder opcode field.
REQ-013 instr_pc  out  64  address of instr.

Function
REQ-014 States: IDLE (none outstanding), WAIT (one outstanding), DROP (outstanding response to discard); at most one request outstanding.
REQ-015 IDLE: imem_req=1, imem_addr=PC, PC<=PC+4 (mod 2^64 wrap), go WAIT, when PCSrc=0 and the buffer has a free slot for the response.
REQ-016 WAIT + imem_rvalid: push {imem_rdata, request PC} into the buffer, go IDLE; a new request issues the following cycle at the earliest.
REQ-017 Latency: request at cycle t, rvalid at t+k -> instr_valid=1 at t+k+1.
REQ-018 instr_valid = buffer non-empty AND PCSrc=0; pop when instr_valid & instr_ready.
REQ-019 While instr_valid=1 and instr_ready=0, instr and instr_pc are held stable.
REQ-020 PCSrc=1: PC<=PCBranch with bits [1:0] forced to 00; buffer flushed; no request issued that cycle; redirect beats a simultaneous pop and push.
REQ-021 PCSrc=1 in WAIT without rvalid -> DROP; with rvalid in the same cycle -> data discarded, IDLE.
REQ-022 DROP: next imem_rvalid discarded, go IDLE; PCSrc=1 in DROP updates PC and stays in DROP.
REQ-023 imem_rvalid in IDLE is ignored.
REQ-024 Buffer full with push and pop in the same cycle: both occur, occupancy unchanged.

Reset
REQ-025 reset_n=0 at a clock edge: PC<=RESET_PC, state IDLE, buffer empty.
REQ-026 Output values during reset: imem_req=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=RESET_PC.
REQ-027 Reset mid-WAIT drops the outstanding request; the late response is ignored per REQ-023.

Configuration
REQ-028 Macro FETCH_BUF2_EN defined: 2-entry buffer; a request issues when occupancy after this cycle's pop is <=1.
REQ-029 FETCH_BUF2_EN undefined: 1-entry buffer; a request issues only when the buffer is empty or is popped this cycle.

Structure
REQ-030 Shared package fetch_pkg holds:
- ADDR_W=64, INSTR_W=32, PC_INCR=4
- fetch_state_t enum {IDLE, WAIT, DROP}
- fetch_entry_t struct {instr, pc}
REQ-031 Sub-module fetch_buffer: parameterised-depth FIFO of fetch_entry_t with push, pop, flush, full and empty.

Verification
REQ-032 Reset then release, instr_ready=1, 1-cycle memory -> imem_addr sequence 0x0, 0x4, 0x8; instr_pc matches; no duplicate or missing words.
REQ-033 instr_ready=0 for 5 cycles with a valid head -> instr/instr_pc stable; with FETCH_BUF2_EN at most 2 entries, without it 1 entry; no further imem_req once full.
REQ-034 PCSrc=1, PCBranch=0x103 while WAIT, rvalid 2 cycles later -> that word discarded; next imem_addr=0x100; instr_valid=0 until the 0x100 word arrives.
REQ-035 PCSrc=1 in the same cycle as imem_rvalid -> word discarded, state IDLE, next request at PCBranch.
REQ-036 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second imem_addr=0x0 (wrap).
REQ-037 reset_n=0 in WAIT, late rvalid after release -> ignored; first instr_pc=RESET_PC.
